// File: rtl/led_chaser_stage.sv
// Autonomous chasing-LED engine driven by a 16-bit GPO control word.
// Bounce or wrap stepping with a prescaled step rate, run/pause and edge-triggered restart.
module led_chaser_stage #(
    parameter int N        = 16,
    parameter int BASE_DIV = 500_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          ctrl,
    output logic [N-1:0]         led,
    output logic [$clog2(N)-1:0] pos,
    output logic                 step,
    output logic                 running
);

    localparam int PW = $clog2(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);
    localparam logic [N-1:0]  ONE  = N'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   count;
    logic [31:0]   limit;
    logic          restart_q;
    logic          pre_en;
    logic          dir;          // 0 = up (toward MSB), 1 = down
    logic          restart;
    logic          active;
    logic          fire;
    logic [PW-1:0] pos_nxt;
    logic          dir_nxt;
    logic          unused_reserved;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ctrl[0])  state_nxt = RUN;
            RUN:  if (!ctrl[0]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        running = (state == RUN);
    end

    always_comb begin
        unused_reserved = ^ctrl[7:4];
        limit   = (32'(ctrl[15:8]) + 32'd1) * 32'(BASE_DIV) - 32'd1;
        restart = ctrl[3] & ~restart_q;
        // pre_en holds the prescaler for the first RUN cycle, so the first
        // step after run rises lands one cycle past a full period.
        active  = pre_en & ctrl[0] & (state == RUN);
        fire    = active & (count >= limit) & ~restart;
    end

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (ctrl[1]) begin
            dir_nxt = ctrl[2];
            if (ctrl[2]) pos_nxt = (pos == '0)   ? LAST : pos - PW'(1);
            else         pos_nxt = (pos == LAST) ? '0   : pos + PW'(1);
        end else if (!dir) begin
            // An outward-pointing dir at an endpoint reflects instead of leaving range.
            if (pos == LAST) begin
                pos_nxt = LAST - PW'(1);
                dir_nxt = 1'b1;
            end else begin
                pos_nxt = pos + PW'(1);
                dir_nxt = (pos_nxt == LAST);
            end
        end else begin
            if (pos == '0) begin
                pos_nxt = PW'(1);
                dir_nxt = 1'b0;
            end else begin
                pos_nxt = pos - PW'(1);
                dir_nxt = (pos_nxt != '0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos       <= '0;
            led       <= ONE;
            step      <= 1'b0;
            dir       <= 1'b0;
            count     <= '0;
            restart_q <= 1'b0;
            pre_en    <= 1'b0;
        end else begin
            restart_q <= ctrl[3];
            pre_en    <= (state == RUN) & ctrl[0];
            step      <= fire;
            if (restart) begin
                pos   <= '0;
                led   <= ONE;
                dir   <= 1'b0;
                count <= '0;
            end else begin
                if (fire) begin
                    pos   <= pos_nxt;
                    led   <= ONE << pos_nxt;
                    count <= '0;
                end else if (active) begin
                    count <= count + 32'd1;
                end else begin
                    count <= '0;
                end
                if (ctrl[1])   dir <= ctrl[2];
                else if (fire) dir <= dir_nxt;
            end
        end
    end

endmodule

// File: tb/tb_led_chaser_stage.sv
// Self-checking bench for led_chaser_stage: directed scenarios plus random control words
// compared every cycle against a behavioural model of the chaser.
module tb_led_chaser_stage;

    localparam int N  = 4;
    localparam int BD = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  ctrl = '0;
    logic [N-1:0] led;
    logic [1:0]   pos;
    logic         step;
    logic         running;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int m_pos, m_dir, m_el;
    bit m_run, m_armed, m_prev3, m_step;

    led_chaser_stage #(.N(N), .BASE_DIV(BD)) dut (
        .clk(clk), .reset(reset), .ctrl(ctrl),
        .led(led), .pos(pos), .step(step), .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("led", 32'(led), 32'(1 << m_pos));
        chk("pos", 32'(pos), 32'(m_pos));
        chk("step", 32'(step), 32'(m_step));
        chk("running", 32'(running), 32'(m_run));
    endtask

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_el = 0;
        m_run = 0; m_armed = 0; m_prev3 = 0; m_step = 0;
    endtask

    task automatic advance(input logic [15:0] c);
        if (c[1]) begin
            m_pos = c[2] ? (m_pos + N - 1) % N : (m_pos + 1) % N;
        end else if (m_dir == 0) begin
            if (m_pos == N - 1) begin m_pos = N - 2; m_dir = 1; end
            else begin m_pos++; if (m_pos == N - 1) m_dir = 1; end
        end else begin
            if (m_pos == 0) begin m_pos = 1; m_dir = 0; end
            else begin m_pos--; if (m_pos == 0) m_dir = 0; end
        end
    endtask

    task automatic model_edge(input logic [15:0] c);
        bit restart;
        int period;
        bit act;
        restart = c[3] && !m_prev3;
        period  = (int'(c[15:8]) + 1) * BD;
        act     = m_run && m_armed && c[0];
        m_step  = 0;
        if (restart) begin
            m_pos = 0; m_dir = 0; m_el = 0;
        end else if (!act) begin
            m_el = 0;
        end else if (m_el >= period - 1) begin
            m_el = 0;
            advance(c);
            m_step = 1;
        end else begin
            m_el++;
        end
        if (!restart && c[1]) m_dir = int'(c[2]);
        m_armed = m_run && c[0];
        m_run   = c[0];
        m_prev3 = c[3];
    endtask

    // Drive ctrl away from the active edge, clock once, check, return on the falling edge.
    task automatic tick(input logic [15:0] c);
        ctrl = c;
        @(posedge clk);
        model_edge(c);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        int first;
        int seen;
        bit found;
        int exp_seq[7];
        int seq[$];
        logic [15:0] c;

        exp_seq = '{1, 2, 3, 2, 1, 0, 1};
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk);
        reset = 1'b0;

        // Bounce, S=0: first-step latency and position sequence
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(16'h0001);
            if (step) begin
                seq.push_back(int'(pos));
                if (first == 0) first = i;
            end
        end
        chk("first_step_latency", 32'(first), 32'd4);
        chk("bounce_step_count", 32'(seq.size() >= 7), 32'd1);
        for (int j = 0; j < 7; j++)
            if (j < seq.size()) chk("bounce_seq", 32'(seq[j]), 32'(exp_seq[j]));

        // Restart at pos=3 (dir down) on the cycle a step is due
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(16'h0001);
            if (step && pos == 2'd3) found = 1;
        end
        chk("reach_pos3_timeout", 32'(found), 32'd1);
        tick(16'h0001);
        tick(16'h0009);
        chk("restart_pos", 32'(pos), 32'd0);
        chk("restart_led", 32'(led), 32'd1);
        chk("restart_step", 32'(step), 32'd0);
        seen = -1;
        for (int i = 0; i < 6; i++) begin
            tick(16'h0009);
            if (step && seen < 0) seen = int'(pos);
        end
        chk("after_restart_pos", 32'(seen), 32'd1);

        // Wrap S=1 downward, then flip direction mid-period
        for (int i = 0; i < 18; i++) tick(16'h0107);
        for (int i = 0; i < 3; i++)  tick(16'h0103);
        for (int i = 0; i < 10; i++) tick(16'h0103);

        // Pause then resume
        for (int i = 0; i < 20; i++) tick(16'h0102);
        for (int i = 0; i < 12; i++) tick(16'h0103);

        // Wrap up to pos 3, switch to bounce: next step must reflect
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(16'h0003);
            if (pos == 2'd3) found = 1;
        end
        chk("wrap_pos3_timeout", 32'(found), 32'd1);
        seen = -1;
        for (int i = 0; i < 10 && seen < 0; i++) begin
            tick(16'h0001);
            if (step) seen = int'(pos);
        end
        chk("wrap_to_bounce_pos", 32'(seen), 32'd2);

        // Slow speed, then drop to S=0 mid-count: step on the next cycle
        for (int i = 0; i < 10; i++) tick(16'hFF01);
        tick(16'h0001);
        chk("speed_change_step", 32'(step), 32'd1);

        // Randomised control words
        c = 16'h0001;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) begin
                c[15:8] = 8'($urandom_range(3));
                c[7:4]  = 4'($urandom);
                c[2]    = 1'($urandom);
                c[1]    = 1'($urandom);
                c[0]    = ($urandom_range(3) != 0);
            end
            c[3] = ($urandom_range(5) == 0);
            tick(c);
        end

        // Asynchronous reset mid-run at pos=2
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick(16'h0001);
            if (pos == 2'd2) found = 1;
        end
        chk("reach_pos2_timeout", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(16'h0001);
            if (step && first == 0) first = i;
        end
        chk("post_reset_latency", 32'(first), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
